// File: rtl/d_ff_switching_pkg.sv
// -----------------------------------------------------------------------------
// d_ff_switching_pkg
//   Shared constants for the switching state register and its select mux.
//   DFS_DEFAULT_WIDTH : default data/state width
//   SEL_HOLD/SEL_LOAD : select encodings for the 2:1 switching mux
// -----------------------------------------------------------------------------
package d_ff_switching_pkg;

    localparam int unsigned DFS_DEFAULT_WIDTH = 4;

    localparam logic SEL_HOLD = 1'b0;
    localparam logic SEL_LOAD = 1'b1;

endpackage : d_ff_switching_pkg

// File: rtl/d_ff_switching_mux.sv
// -----------------------------------------------------------------------------
// switching_mux
//   WIDTH-bit 2:1 combinational select used as the D input of the state
//   register in d_ff_switching.
// Ports:
//   i_sel   : SEL_LOAD picks i_load, anything else picks i_hold
//   i_hold  : hold path (normally the register's own output)
//   i_load  : next-state path
//   o_sel   : selected value
// -----------------------------------------------------------------------------
module switching_mux
    import d_ff_switching_pkg::*;
#(
    parameter int unsigned WIDTH = DFS_DEFAULT_WIDTH
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_hold,
    input  logic [WIDTH-1:0] i_load,
    output logic [WIDTH-1:0] o_sel
);

    // Only the selected input reaches the output, so X/Z on the unselected
    // input cannot leak through.
    always_comb begin
        o_sel = i_hold;
        if (i_sel == SEL_LOAD) begin
            o_sel = i_load;
        end
    end

endmodule : switching_mux

// File: rtl/d_ff_switching.sv
// -----------------------------------------------------------------------------
// d_ff_switching
//   Clock-enabled state register: a 2:1 switching select feeding a D flip-flop.
//   CE=1 loads IN_2 (next state), CE=0 reloads IN_1 (hold path, normally OUT).
// Parameters:
//   WIDTH     : data/state width (>=1)
//   RST_VALUE : value OUT takes on a reset edge
// Ports:
//   CLK           : clock, rising edge
//   RST           : synchronous active-low reset
//   CE            : select / clock enable (1 = IN_2, 0 = IN_1)
//   IN_1          : hold path
//   IN_2          : next-state path
//   OUT_SWITCHING : combinational select result (D input)
//   OUT           : registered state (Q)
//   CHANGED       : registered "OUT took a new value" flag, present only when
//                   D_FF_SWITCHING_CHANGED_EN is defined
// -----------------------------------------------------------------------------
module d_ff_switching
    import d_ff_switching_pkg::*;
#(
    parameter int unsigned            WIDTH     = DFS_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]       RST_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WIDTH-1:0] IN_1,
    input  logic [WIDTH-1:0] IN_2,
    output logic [WIDTH-1:0] OUT_SWITCHING,
    output logic [WIDTH-1:0] OUT
`ifdef D_FF_SWITCHING_CHANGED_EN
    ,
    output logic             CHANGED
`endif
);

    logic [WIDTH-1:0] w_switching;
    logic [WIDTH-1:0] r_out;

    switching_mux #(
        .WIDTH (WIDTH)
    ) u_switching_mux (
        .i_sel  (CE),
        .i_hold (IN_1),
        .i_load (IN_2),
        .o_sel  (w_switching)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_out <= RST_VALUE;
        end else begin
            r_out <= w_switching;
        end
    end

    assign OUT_SWITCHING = w_switching;
    assign OUT           = r_out;

`ifdef D_FF_SWITCHING_CHANGED_EN
    logic r_changed;

    // Compares the value about to be loaded with the current state, so the
    // flag is high in the cycle where OUT already shows the new value.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= (w_switching != r_out);
        end
    end

    assign CHANGED = r_changed;
`endif

endmodule : d_ff_switching

// File: tb/tb_d_ff_switching.sv
module tb_d_ff_switching;

    logic       clk;
    logic       rst;
    logic       ce;
    logic [3:0] in_1;
    logic [3:0] in_2;
    logic [3:0] out_sw;
    logic [3:0] out_q;
    logic       changed;

    // Bench-side drive / parent-logic selection
    logic [3:0] in_1_drv;
    logic [3:0] in_2_drv;
    bit         tie_hold;
    bit         use_ns;

    typedef struct {
        logic [3:0] out;
        logic       chg;
        bit         chk_chg;
    } exp_t;

    exp_t sb[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Parent down-counter next-state logic: 5 -> 14, 6..14 -> n-1, else -> 5
    function automatic logic [3:0] ns(input logic [3:0] n);
        if (n == 4'd5)                   return 4'd14;
        else if (n >= 4'd6 && n <= 4'd14) return n - 4'd1;
        else                             return 4'd5;
    endfunction

    assign in_1 = tie_hold ? out_q     : in_1_drv;
    assign in_2 = use_ns   ? ns(out_q) : in_2_drv;

    d_ff_switching #(
        .WIDTH     (4),
        .RST_VALUE (4'h0)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .CE            (ce),
        .IN_1          (in_1),
        .IN_2          (in_2),
        .OUT_SWITCHING (out_sw),
        .OUT           (out_q)
`ifdef D_FF_SWITCHING_CHANGED_EN
        ,
        .CHANGED       (changed)
`endif
    );

`ifndef D_FF_SWITCHING_CHANGED_EN
    assign changed = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, check the combinational
    // select immediately, and queue the OUT expected after the next rising edge.
    task automatic step(input logic rst_v, input logic ce_v, input bit tie, input bit nsm,
                        input logic [3:0] i1, input logic [3:0] i2,
                        input logic [3:0] exp_out, input logic [3:0] exp_sw,
                        input logic exp_chg, input bit chk_chg);
        exp_t e;
        @(negedge clk);
        rst      = rst_v;
        ce       = ce_v;
        tie_hold = tie;
        use_ns   = nsm;
        in_1_drv = i1;
        in_2_drv = i2;
        #1;
        chk("out_switching", out_sw, exp_sw);
        e.out     = exp_out;
        e.chg     = exp_chg;
        e.chk_chg = chk_chg;
        sb.push_back(e);
    endtask

    // Monitor: after every rising edge, pop and compare any pending expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out", out_q, e.out);
`ifdef D_FF_SWITCHING_CHANGED_EN
                if (e.chk_chg) chk("changed", {3'b000, changed}, {3'b000, e.chg});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [12];
        int unsigned waited;
        seq = '{4'd5, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd14};

        rst = 1'b0; ce = 1'b0; tie_hold = 1'b0; use_ns = 1'b0;
        in_1_drv = 4'h0; in_2_drv = 4'h0;

        // 1. reset overrides CE/IN_2
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'hA, 4'h0, 4'hA, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'hA, 4'h0, 4'hA, 1'b0, 1'b1);

        // 2. load after exactly one edge
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h5, 4'h5, 4'h5, 1'b0, 1'b0);
        chk("load_not_early", out_q, 4'h0);

        // X on the unselected input must not reach OUT_SWITCHING
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'bxxxx, 4'h5, 4'h5, 4'h5, 1'b0, 1'b0);

        // 3. hold with IN_1 tied to OUT while IN_2 toggles
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, (i % 2 == 0) ? 4'hE : 4'h3,
                 4'h5, 4'h5, 1'b0, 1'b0);
        end

        // 4. down-counter loop from OUT=0 (OUT=5 now, so ns gives E during reset)
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'hE, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, seq[i], seq[i], 1'b0, 1'b0);
        end

        // 5. continue to C, then reset mid-operation
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'hD, 4'hD, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'hC, 4'hC, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'hB, 1'b0, 1'b1);
        chk("reset_waits_for_edge", out_q, 4'hC);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h5, 4'h5, 1'b0, 1'b0);

        // 6. CHANGED: 5 -> 7 (new), 7 -> 7 (same), 7 -> 8 (new)
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h7, 4'h7, 4'h7, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h7, 4'h7, 4'h7, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h8, 4'h8, 4'h8, 1'b1, 1'b1);

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #3;
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_d_ff_switching
